// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_seq
//  Description : Sequential unsigned multiply/divide unit with HI/LO result
//                registers. MULTU uses radix-2 shift-add; DIVU uses restoring
//                division. Each runs one bit per cycle for `wide` cycles.
//                HI/LO accept direct writes (MTHI/MTLO) when the unit is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int wide = 32
) (
    input  logic            clk,
    input  logic            rst,      // asynchronous, active-low
    input  logic            start,
    input  logic            op,       // 0 = MULTU, 1 = DIVU
    input  logic [wide-1:0] a,
    input  logic [wide-1:0] b,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [wide-1:0] wd,
    output logic            busy,
    output logic            done,
    output logic            dbz,
    output logic [wide-1:0] hi,
    output logic [wide-1:0] lo
);

    localparam int            CW        = $clog2(wide) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(wide - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(wide);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [wide-1:0]     opa_q,   opa_d;    // multiplicand / dividend
    logic [wide-1:0]     opb_q,   opb_d;    // divisor
    logic [2*wide-1:0]   prod_q,  prod_d;   // {partial product, multiplier}
    logic [wide:0]       rem_q,   rem_d;    // shifted partial remainder
    logic [wide-1:0]     quo_q,   quo_d;    // {dividend bits left, quotient bits}
    logic [wide-1:0]     hi_q,    hi_d;
    logic [wide-1:0]     lo_q,    lo_d;
    logic                dbz_q,   dbz_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic [wide:0]       w_mul_sum;
    logic [2*wide-1:0]   w_prod_next;
    logic [wide:0]       w_div_diff;
    logic                w_div_ok;
    logic [wide-1:0]     w_rem_keep;
    logic [wide-1:0]     w_quo_next;
    logic [wide-1:0]     w_a_shl;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_last;

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign w_mul_sum   = {1'b0, prod_q[2*wide-1:wide]}
                       + {1'b0, (prod_q[0] ? opa_q : {wide{1'b0}})};
    assign w_prod_next = {w_mul_sum, prod_q[wide-1:1]};

    // Restoring step: rem_q already holds {remainder, next dividend bit}.
    // Since that value is below 2*divisor, the (wide+1)-bit difference fits
    // and its MSB is a valid sign bit.
    assign w_div_diff  = rem_q - {1'b0, opb_q};
    assign w_div_ok    = ~w_div_diff[wide];
    assign w_rem_keep  = w_div_ok ? w_div_diff[wide-1:0] : rem_q[wide-1:0];
    assign w_quo_next  = {quo_q[wide-2:0], w_div_ok};
    assign w_a_shl     = a << 1;

    // The iteration counter saturates instead of wrapping.
    assign w_cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign w_last      = (cnt_q == LAST_ITER);

    // Next-state and datapath update; every target defaults to hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Start wins over any direct register write on this edge.
                    opa_d   = a;
                    opb_d   = b;
                    cnt_d   = '0;
                    prod_d  = {{wide{1'b0}}, b};
                    rem_d   = {{wide{1'b0}}, a[wide-1]};
                    quo_d   = w_a_shl;
                    state_d = op ? DIV : MUL;
                end else begin
                    state_d = IDLE;
                    if (we_hi) hi_d = wd;
                    if (we_lo) lo_d = wd;
                end
            end

            MUL: begin
                prod_d = w_prod_next;
                cnt_d  = w_cnt_inc;
                if (w_last) begin
                    state_d = DONE;
                    hi_d    = w_prod_next[2*wide-1:wide];
                    lo_d    = w_prod_next[wide-1:0];
                    dbz_d   = 1'b0;
                end
            end

            DIV: begin
                if (opb_q == {wide{1'b0}}) begin
                    // Divide by zero: no iterations, fixed result.
                    state_d = DONE;
                    hi_d    = opa_q;
                    lo_d    = {wide{1'b1}};
                    dbz_d   = 1'b1;
                end else begin
                    rem_d = {w_rem_keep, quo_q[wide-1]};
                    quo_d = w_quo_next;
                    cnt_d = w_cnt_inc;
                    if (w_last) begin
                        state_d = DONE;
                        hi_d    = w_rem_keep;
                        lo_d    = w_quo_next;
                        dbz_d   = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = (state_q == MUL) || (state_q == DIV);
    assign done = (state_q == DONE);
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter: wide, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port: start  input  1  request a new operation; sampled on clk rising edge.
REQ-005 SHALL have port: op  input  1  0 = MULTU, 1 = DIVU.
REQ-006 SHALL have port: a, b  input  wide  unsigned operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-007 SHALL have port: we_hi, we_lo  input  1  direct register writes (MTHI/MTLO).
REQ-008 SHALL have port: wd  input  wide  data for we_hi/we_lo.
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: dbz  output  1  last DIVU had b = 0.
REQ-012 SHALL have port: hi, lo  output  wide  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE; busy=1 only in MUL/DIV; done=1 only in DONE.
REQ-014 SHALL accept start only in IDLE or DONE; it SHALL latch a, b and op, clear the iteration counter, and go to MUL (op=0) or DIV (op=1).
REQ-015 SHALL ignore start while busy=1, with no effect on operands, counter or outputs.
REQ-016 MUL SHALL be radix-2 shift-add, one bit per cycle, with a 2*wide product accumulator.
REQ-017 DIV SHALL be restoring division, one quotient bit per cycle, with a wide+1-bit partial remainder.
REQ-018 MUL/DIV SHALL run exactly wide iterations; the edge completing the last iteration SHALL enter DONE and write hi/lo.
REQ-019 done SHALL therefore rise exactly wide edges after the start-capture edge.
REQ-020 MULTU result: {hi, lo} = a*b, full 2*wide bits, no truncation.
REQ-021 DIVU result: lo = a / b, hi = a % b.
REQ-022 DIVU with b=0 SHALL skip iteration and enter DONE on the edge after capture, with lo = all ones, hi = a, dbz=1.
REQ-023 dbz SHALL update on every DONE entry (0 for MULTU or nonzero divisor) and hold otherwise.
REQ-024 hi/lo SHALL hold their previous values throughout MUL/DIV; intermediate results are internal only.
REQ-025 DONE SHALL last one cycle, then go to IDLE, or to MUL/DIV if start=1 (back-to-back).
REQ-026 we_hi/we_lo SHALL write wd to hi/lo at the edge, only in IDLE or DONE with start=0; both set writes both.
REQ-027 A we_hi/we_lo write SHALL be dropped when busy=1 or when start=1 on the same edge (start has priority).
REQ-028 The iteration counter SHALL be $clog2(wide)+1 bits; it SHALL NOT wrap.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, counter=0 and accumulators=0.
REQ-030 rst=0 mid-operation SHALL abort the operation; no done pulse and no hi/lo update SHALL follow release.
REQ-031 After rst returns to 1, start SHALL be accepted at the first rising edge.

Verification
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 32 edges after capture, hi=0xFFFFFFFE, lo=0x00000001, dbz=0; busy=1 for 32 cycles.
REQ-033 DIVU a=100 b=7 -> lo=14, hi=2, dbz=0, done after 32 edges; then DIVU a=5 b=9 -> lo=0, hi=5.
REQ-034 DIVU a=0x1234 b=0 -> done on the edge after capture, lo=0xFFFFFFFF, hi=0x00001234, dbz=1.
REQ-035 With hi=0x11 lo=0x22, MULTU 3*4, then start and we_hi(wd=0x99) pulsed at cycle 5 -> hi=0x11 lo=0x22 until done, then hi=0, lo=12; no second operation.
REQ-036 rst=0 asynchronously at cycle 10 of MULTU -> busy, hi, lo, dbz go to 0 immediately; no done pulse for 40 cycles after release.
REQ-037 In IDLE, we_lo=1 wd=0xDEADBEEF -> lo=0xDEADBEEF next edge, hi unchanged; start asserted in DONE -> new op captured, busy=1 next cycle.
